// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response codes and data/strobe widths.
package axi_lite_pkg;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;
endpackage

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: NUM_REGS x 32-bit storage with byte-enable write and combinational read.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IW       = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we_i,
    input  logic [IW-1:0]                  widx_i,
    input  logic [AXI_DATA_W-1:0]          wdata_i,
    input  logic [AXI_STRB_W-1:0]          wstrb_i,
    input  logic [IW-1:0]                  ridx_i,
    output logic [AXI_DATA_W-1:0]          rdata_o,
    output logic [AXI_DATA_W*NUM_REGS-1:0] regs_o
);
    logic [AXI_DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
        end else if (we_i) begin
            for (int b = 0; b < AXI_STRB_W; b++)
                if (wstrb_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    assign rdata_o = mem_q[ridx_i];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_o[AXI_DATA_W*i +: AXI_DATA_W] = mem_q[i];
    end
endmodule

// File: rtl/axi4_lite_slave_regs.sv
// axi4_lite_slave_regs: AXI4-Lite responder over a register bank, AW/W accepted in any order.
module axi4_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int  NUM_REGS   = 8,
    parameter int  ADDR_WIDTH = 32,
    localparam int IW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [AXI_DATA_W-1:0]          S_AXI_WDATA,
    input  logic [AXI_STRB_W-1:0]          S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [AXI_DATA_W-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [AXI_DATA_W*NUM_REGS-1:0] regs_out,
    output logic                           wr_pulse,
    output logic [IW-1:0]                  wr_index
);
    localparam logic [ADDR_WIDTH-1:0] NREGS = ADDR_WIDTH'(NUM_REGS);

    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic                  wr_pulse_q, wr_pulse_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [AXI_DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, rf_rdata;
    logic [AXI_STRB_W-1:0] wstrb_q, wstrb_d;
    logic [IW-1:0]         wr_index_q, wr_index_d;
    resp_t                 bresp_q, bresp_d, rresp_q, rresp_d;
    logic                  aw_hs, w_hs, ar_hs, commit, aw_ok, ar_ok;

    assign S_AXI_AWREADY = !aw_held_q && !bvalid_q;
    assign S_AXI_WREADY  = !w_held_q && !bvalid_q;
    assign S_AXI_ARREADY = !rvalid_q;
    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = aw_held_q && w_held_q;
    // Any address bit beyond the register range makes the index invalid.
    assign aw_ok  = (awaddr_q >> 2) < NREGS;
    assign ar_ok  = (S_AXI_ARADDR >> 2) < NREGS;

    always_comb begin
        aw_held_d  = commit ? 1'b0 : (aw_hs ? 1'b1 : aw_held_q);
        w_held_d   = commit ? 1'b0 : (w_hs ? 1'b1 : w_held_q);
        awaddr_d   = aw_hs ? S_AXI_AWADDR : awaddr_q;
        wdata_d    = w_hs ? S_AXI_WDATA : wdata_q;
        wstrb_d    = w_hs ? S_AXI_WSTRB : wstrb_q;
        bvalid_d   = commit ? 1'b1 : (S_AXI_BREADY ? 1'b0 : bvalid_q);
        bresp_d    = commit ? (aw_ok ? OKAY : SLVERR) : bresp_q;
        wr_pulse_d = commit && aw_ok;
        wr_index_d = (commit && aw_ok) ? awaddr_q[IW+1:2] : wr_index_q;
        rvalid_d   = ar_hs ? 1'b1 : (S_AXI_RREADY ? 1'b0 : rvalid_q);
        rdata_d    = ar_hs ? (ar_ok ? rf_rdata : '0) : rdata_q;
        rresp_d    = ar_hs ? (ar_ok ? OKAY : SLVERR) : rresp_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            wr_pulse_q <= 1'b0;
            wr_index_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            wr_index_q <= wr_index_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    axi_lite_regfile #(.NUM_REGS(NUM_REGS), .IW(IW)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (commit && aw_ok),
        .widx_i  (awaddr_q[IW+1:2]),
        .wdata_i (wdata_q),
        .wstrb_i (wstrb_q),
        .ridx_i  (S_AXI_ARADDR[IW+1:2]),
        .rdata_o (rf_rdata),
        .regs_o  (regs_out)
    );

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;
    assign wr_pulse     = wr_pulse_q;
    assign wr_index     = wr_index_q;
endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
AXI4-Lite responder that pairs with the team's AXI4-Lite master. It exposes a bank of NUM_REGS 32-bit control/status registers through the slave side of the interface. It accepts AW and W independently and in either order, with one outstanding write and one outstanding read at a time. The register contents drive user logic directly, and a one-cycle strobe flags each committed write.

Parameters:
NUM_REGS, 8, number of 32-bit registers; must be >= 1; word-addressed at byte offsets 0, 4, 8, ...
ADDR_WIDTH, 32, width of AWADDR/ARADDR

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous, active-low reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables; bit i covers WDATA[8i+7:8i]
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
regs_out  out  32*NUM_REGS  flattened register contents; register i at [32i+31:32i]
wr_pulse  out  1  one-cycle pulse when a write commits to a valid register
wr_index  out  $clog2(NUM_REGS) (min 1)  register index of the last committed write; valid while wr_pulse=1

Behaviour:
- Reset (rst_n=0 at a rising edge), applied on the next edge:
  - All registers, aw_held, w_held, BVALID, RVALID and wr_pulse go to 0.
  - RDATA, BRESP and RRESP go to 0.
  - The ready outputs are combinational from the flags, so AWREADY/WREADY/ARREADY read 1 in the first cycle after reset.
  - Reset mid-transaction abandons it: no response is issued and no register is written.
- Address decode:
  - Word index = addr >> 2; addr[1:0] is ignored.
  - An address is valid iff index < NUM_REGS; any upper address bit set beyond that range is invalid.
- Write path:
  - Internal latches hold the captured address (aw_held) and data/strobe (w_held).
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - An AW handshake (AWVALID && AWREADY) sets aw_held. A W handshake sets w_held. They complete in the same cycle or in any order, any gap apart.
  - Commit edge is the first edge where aw_held && w_held:
    - If the index is valid, each byte with WSTRB[i]=1 is updated and the others are kept.
    - BVALID=1 and BRESP = OKAY (2'b00) if valid, SLVERR (2'b10) if invalid.
    - For a valid write, wr_pulse=1 for exactly one cycle and wr_index=index.
    - aw_held and w_held are cleared.
  - Latency: handshakes at edge k, commit and BVALID at edge k+1, new value visible on regs_out from k+1.
  - BVALID and BRESP stay stable until BREADY=1 (cleared on the BVALID && BREADY edge).
  - While BVALID=1, no new AW or W is accepted.
  - WSTRB=0 gives an OKAY response with the register unchanged; wr_pulse still fires.
- Read path:
  - ARREADY = !RVALID.
  - On an AR handshake at edge k: RVALID=1 at edge k.
    - If the index is valid, RDATA = register value before any write committing on that same edge, and RRESP = OKAY.
    - If invalid, RDATA = 0 and RRESP = SLVERR.
  - RDATA, RRESP and RVALID stay stable until the RVALID && RREADY edge. ARREADY is low meanwhile.
  - A back-to-back read needs one bubble cycle after the R handshake.
- Independence:
  - Read and write channels operate concurrently.
  - A read of a register whose write commits on the same edge returns the old value.
- No AXI ordering is imposed between the read and write channels.

Decomposition:
- Package axi_lite_pkg holds:
  - resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - constants AXI_DATA_W=32 and AXI_STRB_W=4.
- One sub-module, axi_lite_regfile, holds NUM_REGS x 32 storage with byte-enable write, a combinational read port and the flattened output.
- Handshake and response logic stays in the top.

Test Plan:
- Full write then read: AW 0x04 and W 0xDEADBEEF/strb 4'hF in the same cycle, BREADY=1 → BVALID one cycle later with BRESP=00, wr_pulse with wr_index=1, regs_out[63:32]=0xDEADBEEF. Then AR 0x04 → RDATA=0xDEADBEEF, RRESP=00.
- Partial strobe: reg1=0xDEADBEEF, write 0x12345678 with strb 4'b0011 → reg1=0xDEAD5678 and readback matches.
- Channel skew: W (0xA5A5A5A5 to 0x08) presented 3 cycles before AW → WREADY drops after the W handshake, exactly one BVALID with OKAY, reg2=0xA5A5A5A5. Repeat with AW first.
- Decode error (NUM_REGS=8): write to 0x20 → BRESP=10, no wr_pulse, all registers unchanged. Read 0x20 → RDATA=0, RRESP=10. Read 0x1E → reg7, OKAY.
- Backpressure: hold BREADY=0 for 5 cycles → BVALID/BRESP stable, AWREADY=WREADY=0 throughout. Hold RREADY=0 for 5 cycles → RVALID/RDATA stable, ARREADY=0.
- Reset mid-op: assert rst_n=0 with aw_held=1 and RVALID=1 pending → next cycle BVALID=RVALID=0, regs_out=0, all readies 1, and a following write completes normally.
